vga_timing_dither: RTL
======================

// Module: vga_timing_dither
// PURPOSE
//   Parametrised VGA raster timing generator with an ordered-dither colour output stage.
//   Produces h/v counters, a frame counter, line/frame strobes and sync pulses, with
//   configurable timing and sync polarity. Reduces IN_BITS-per-channel colour from the
//   effect mux to OUT_BITS-per-channel using a truncate, spatial 4x4 Bayer or temporal
//   4x4 Bayer mode. Sits between the demo effect logic and the pads.
// PARAMETERS
//   H_DISPLAY     1220  active pixels (clocks) per line
//   H_FRONT_PORCH 31    clocks from end of active to hsync assert
//   H_SYNC_PULSE  183   hsync width, clocks
//   H_BACK_PORCH  91    clocks after hsync; H_TOTAL = sum of the four H parameters = 1525
//   V_DISPLAY     480   active lines
//   V_FRONT_PORCH 10    lines from end of active to vsync assert
//   V_SYNC_PULSE  2     vsync width, lines
//   V_BACK_PORCH  33    lines after vsync; V_TOTAL = sum of the four V parameters = 525
//   HSYNC_POL     0     active level of hsync (0 = active-low)
//   VSYNC_POL     0     active level of vsync (0 = active-low)
//   PRELINE_LEAD  16    preline_strobe fires when h_count == H_DISPLAY-PRELINE_LEAD; range 1..H_DISPLAY-1
//   FRAME_BITS    11    frame counter width
//   IN_BITS       6     input colour bits per channel
//   OUT_BITS      2     output colour bits per channel; must be < IN_BITS
//   DITHER_MODE   1     0 = truncate, 1 = spatial 4x4 Bayer, 2 = temporal 4x4 Bayer
// PORTS
//   clk48          in   1            pixel clock
//   rst_n          in   1            asynchronous reset, active-low
//   r_in,g_in,b_in in   IN_BITS      colour for the current h_count/v_count, same cycle
//   h_count        out  clog2(H_TOTAL) horizontal counter (register)
//   v_count        out  clog2(V_TOTAL) vertical counter (register)
//   frame          out  FRAME_BITS   frame counter (register), wraps modulo 2^FRAME_BITS
//   display_active out  1            h_count<H_DISPLAY && v_count<V_DISPLAY (comb decode)
//   preline_strobe out  1            1 clk, every line including blank lines (divider start)
//   hblank_strobe  out  1            1 clk when h_count == H_DISPLAY, every line
//   frame_strobe   out  1            1 clk when h_count==H_TOTAL-1 && v_count==V_TOTAL-1
//   hsync,vsync    out  1            registered sync outputs
//   r_out,g_out,b_out out OUT_BITS   registered dithered colour
// BEHAVIOUR
//   Reset (async, rst_n low): h_count=0, v_count=0, frame=0; hsync=!HSYNC_POL,
//     vsync=!VSYNC_POL; colour outputs 0. Takes effect immediately, mid-line included;
//     counting resumes from 0 on the first clk48 edge after rst_n rises.
//   Counters: h_count increments every clock; at H_TOTAL-1 it wraps to 0 and v_count
//     increments. At the v_count wrap V_TOTAL-1 -> 0, frame increments on the same edge.
//   Strobes: combinational decode of the counter registers, high for exactly 1 clock.
//   Sync: registered; 1-clock latency from counter value to pin.
//     hsync = HSYNC_POL while h_count in [H_DISPLAY+H_FRONT_PORCH, +H_SYNC_PULSE).
//     vsync = VSYNC_POL while v_count in [V_DISPLAY+V_FRONT_PORCH, +V_SYNC_PULSE),
//     for whole lines.
//   Colour: registered; 1-clock latency, aligned with sync. Output 0 when !display_active.
//   Dither: D = IN_BITS-OUT_BITS; i = h_count[1:0], j = v_count[1:0].
//     Mode 2 uses i = h_count[1:0] ^ {1'b0, frame[0]}.
//     t4 = {i0^j0, j0, i1^j1, j1}; row j=0 gives 0,8,2,10.
//     t = D>=4 ? t4<<(D-4) : t4>>(4-D); mode 0 uses t=0.
//     out = min(({1'b0,c}+t) >> D, 2^OUT_BITS-1). The sum is IN_BITS+1 wide; saturate, never wrap.
//   No other state. Parameter legality is checked at elaboration ($error).
// TESTING
//   1 Reset release, defaults: hsync falls 1 clk after h_count=1251, stays low 183 clks,
//     period 1525 clks.
//   2 vsync low exactly 2 lines, from v_count=490 to 491 inclusive.
//     frame_strobe 1 clk at (1524,524); frame 0->1 on the next edge.
//     Run 2048 frames: frame wraps 2047->0.
//   3 Mode 1, 6->2: c=0 gives 0 everywhere; c=63 gives 3 (saturated); c=32 gives 2
//     everywhere; c=40 gives 3 on exactly 8 of 16 tile pixels.
//   4 Mode 2, c=40: per-pixel pattern on odd frames = even-frame pattern with the
//     h_count[0] columns swapped; mode 0, c=47 gives 2.
//   5 Inputs at 63 throughout: colour out 0 for h_count>=1220 or v_count>=480.
//     preline_strobe at h=1204 and hblank_strobe at h=1220, once per line for all 525 lines.
//   6 rst_n low at (700,100): outputs 0 and syncs inactive with no clock edge.
//     After release, h_count counts 0,1,2 and first hsync falls 1252 clks later.

Source files
------------

// File: rtl/vga_timing_dither.sv
// vga_timing_dither: VGA raster timing generator with an ordered-dither colour stage.
// Produces the h/v/frame counters, line and frame strobes and registered sync pulses,
// and narrows each colour channel by truncation or a spatial/temporal 4x4 Bayer dither.
module vga_timing_dither #(
  parameter int H_DISPLAY     = 1220,
  parameter int H_FRONT_PORCH = 31,
  parameter int H_SYNC_PULSE  = 183,
  parameter int H_BACK_PORCH  = 91,
  parameter int V_DISPLAY     = 480,
  parameter int V_FRONT_PORCH = 10,
  parameter int V_SYNC_PULSE  = 2,
  parameter int V_BACK_PORCH  = 33,
  parameter int HSYNC_POL     = 0,
  parameter int VSYNC_POL     = 0,
  parameter int PRELINE_LEAD  = 16,
  parameter int FRAME_BITS    = 11,
  parameter int IN_BITS       = 6,
  parameter int OUT_BITS      = 2,
  parameter int DITHER_MODE   = 1,
  localparam int H_TOTAL = H_DISPLAY + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH,
  localparam int V_TOTAL = V_DISPLAY + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH,
  localparam int HW      = $clog2(H_TOTAL),
  localparam int VW      = $clog2(V_TOTAL)
) (
  input  logic                  clk48,
  input  logic                  rst_n,
  input  logic [IN_BITS-1:0]    r_in,
  input  logic [IN_BITS-1:0]    g_in,
  input  logic [IN_BITS-1:0]    b_in,
  output logic [HW-1:0]         h_count,
  output logic [VW-1:0]         v_count,
  output logic [FRAME_BITS-1:0] frame,
  output logic                  display_active,
  output logic                  preline_strobe,
  output logic                  hblank_strobe,
  output logic                  frame_strobe,
  output logic                  hsync,
  output logic                  vsync,
  output logic [OUT_BITS-1:0]   r_out,
  output logic [OUT_BITS-1:0]   g_out,
  output logic [OUT_BITS-1:0]   b_out
);

  localparam int D   = IN_BITS - OUT_BITS;
  localparam int SW  = IN_BITS + 1;
  localparam int SHL = (D >= 4) ? D - 4 : 0;
  localparam int SHR = (D >= 4) ? 0 : 4 - D;
  localparam logic [SW-1:0] OUT_MAX = SW'((1 << OUT_BITS) - 1);
  localparam logic HS_ON = (HSYNC_POL != 0);
  localparam logic VS_ON = (VSYNC_POL != 0);

  localparam logic [31:0] H_DISP_U   = H_DISPLAY;
  localparam logic [31:0] V_DISP_U   = V_DISPLAY;
  localparam logic [31:0] H_LAST_U   = H_TOTAL - 1;
  localparam logic [31:0] V_LAST_U   = V_TOTAL - 1;
  localparam logic [31:0] H_PRE_U    = H_DISPLAY - PRELINE_LEAD;
  localparam logic [31:0] HS_START_U = H_DISPLAY + H_FRONT_PORCH;
  localparam logic [31:0] HS_END_U   = H_DISPLAY + H_FRONT_PORCH + H_SYNC_PULSE;
  localparam logic [31:0] VS_START_U = V_DISPLAY + V_FRONT_PORCH;
  localparam logic [31:0] VS_END_U   = V_DISPLAY + V_FRONT_PORCH + V_SYNC_PULSE;

  // Illegal parameter sets stop elaboration rather than producing a broken raster
  if (OUT_BITS < 1 || OUT_BITS >= IN_BITS) begin : gBadBits
    $error("vga_timing_dither: OUT_BITS must be in 1..IN_BITS-1");
  end
  if (DITHER_MODE < 0 || DITHER_MODE > 2) begin : gBadMode
    $error("vga_timing_dither: DITHER_MODE must be 0, 1 or 2");
  end
  if (PRELINE_LEAD < 1 || PRELINE_LEAD > H_DISPLAY - 1) begin : gBadLead
    $error("vga_timing_dither: PRELINE_LEAD must be in 1..H_DISPLAY-1");
  end
  if (FRAME_BITS < 1 || H_SYNC_PULSE < 1 || V_SYNC_PULSE < 1) begin : gBadWidths
    $error("vga_timing_dither: FRAME_BITS and sync pulse widths must be at least 1");
  end
  if (H_TOTAL < 4 || V_TOTAL < 4) begin : gBadTotals
    $error("vga_timing_dither: raster must be at least 4x4 for the dither tile");
  end

  logic [HW-1:0]         hCount_q, hCount_d;
  logic [VW-1:0]         vCount_q, vCount_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;
  logic                  hsync_q, hsync_d;
  logic                  vsync_q, vsync_d;
  logic [OUT_BITS-1:0]   r_q, r_d, g_q, g_d, b_q, b_d;
  logic [31:0]           hNow, vNow;
  logic                  hsyncActive, vsyncActive;
  logic [1:0]            iIdx, jIdx;
  logic [3:0]            t4;
  logic [SW-1:0]         threshold;

  // Add the threshold with one spare bit, drop the low bits, and clamp instead of wrapping
  function automatic logic [OUT_BITS-1:0] ditherChannel(input logic [IN_BITS-1:0] c,
                                                        input logic [SW-1:0] t);
    logic [SW-1:0] sum;
    logic [SW-1:0] q;
    sum = {1'b0, c} + t;
    q   = sum >> D;
    if (q > OUT_MAX) return OUT_MAX[OUT_BITS-1:0];
    return q[OUT_BITS-1:0];
  endfunction

  assign hNow = 32'(hCount_q);
  assign vNow = 32'(vCount_q);

  assign display_active = (hNow < H_DISP_U) && (vNow < V_DISP_U);
  assign preline_strobe = (hNow == H_PRE_U);
  assign hblank_strobe  = (hNow == H_DISP_U);
  assign frame_strobe   = (hNow == H_LAST_U) && (vNow == V_LAST_U);
  assign hsyncActive    = (hNow >= HS_START_U) && (hNow < HS_END_U);
  assign vsyncActive    = (vNow >= VS_START_U) && (vNow < VS_END_U);

  // Raster advance: pixel every clock, line at end of row, frame at end of last line
  always_comb begin
    hCount_d = hCount_q + 1'b1;
    vCount_d = vCount_q;
    frame_d  = frame_q;
    if (hNow == H_LAST_U) begin
      hCount_d = '0;
      if (vNow == V_LAST_U) begin
        vCount_d = '0;
        frame_d  = frame_q + 1'b1;
      end else begin
        vCount_d = vCount_q + 1'b1;
      end
    end
  end

  // Bayer threshold for this pixel, then sync levels and dithered colour for the next clock
  always_comb begin
    iIdx = hCount_q[1:0];
    if (DITHER_MODE == 2) iIdx = hCount_q[1:0] ^ {1'b0, frame_q[0]};
    jIdx = vCount_q[1:0];
    t4   = {iIdx[0] ^ jIdx[0], jIdx[0], iIdx[1] ^ jIdx[1], jIdx[1]};
    threshold = '0;
    if (DITHER_MODE != 0) threshold = SW'(t4 >> SHR) << SHL;
    hsync_d = hsyncActive ? HS_ON : !HS_ON;
    vsync_d = vsyncActive ? VS_ON : !VS_ON;
    r_d = '0;
    g_d = '0;
    b_d = '0;
    if (display_active) begin
      r_d = ditherChannel(r_in, threshold);
      g_d = ditherChannel(g_in, threshold);
      b_d = ditherChannel(b_in, threshold);
    end
  end

  // All state registers; reset parks the raster at the origin with syncs inactive
  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      hCount_q <= '0;
      vCount_q <= '0;
      frame_q  <= '0;
      hsync_q  <= !HS_ON;
      vsync_q  <= !VS_ON;
      r_q      <= '0;
      g_q      <= '0;
      b_q      <= '0;
    end else begin
      hCount_q <= hCount_d;
      vCount_q <= vCount_d;
      frame_q  <= frame_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      r_q      <= r_d;
      g_q      <= g_d;
      b_q      <= b_d;
    end
  end

  assign h_count = hCount_q;
  assign v_count = vCount_q;
  assign frame   = frame_q;
  assign hsync   = hsync_q;
  assign vsync   = vsync_q;
  assign r_out   = r_q;
  assign g_out   = g_q;
  assign b_out   = b_q;

endmodule
